sram128x8_ctrl: RTL and testbench
=================================

# sram128x8_ctrl

Request-side controller for the 128x8 single-port SRAM macro (gf180mcu_fd_ip_sram__sram128x8m8wm1). It converts a valid/ready request stream into the macro's active-low CEN/GWEN/WEN pin protocol and returns read data through a credit-protected response FIFO. After reset it can sweep the whole array to a known value before accepting traffic. It sits between on-chip masters and the macro pins, in the same clock domain as the macro.

## Interface

- INIT_EN, 1, when 1 the controller writes INIT_VALUE to all 128 words after reset; when 0 it skips the sweep.
- INIT_VALUE, 8'h00, data written during the sweep.
- RSP_DEPTH, 4, response FIFO depth and read-credit limit; legal range 1–8.
- CLK  in  1  clock; also drives the SRAM macro CLK.
- RSTN  in  1  asynchronous reset, active low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at a CLK rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  7  word address.
- req_wdata  in  8  write data.
- req_wmask  in  8  active-high per-bit write enable.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at an edge.
- rsp_rdata  out  8  read data.
- init_done  out  1  high once the sweep is complete; stays high until reset.
- CEN  out  1  macro chip enable, active low.
- GWEN  out  1  macro global write enable, active low.
- WEN  out  8  macro bit write enables, active low.
- A  out  7  macro address.
- D  out  8  macro write data.
- Q  in  8  macro read data.

## Operation

- FSM states: INIT and RUN. Reset enters INIT. When INIT_EN=0, the FSM moves to RUN on the first edge.
- INIT: a 7-bit counter runs 0..127. Each cycle the controller drives CEN=0, GWEN=0, WEN=8'h00, A=cnt, D=INIT_VALUE. After the count-127 write it goes to RUN and sets init_done=1. req_ready is 0 throughout INIT.
- RUN: req_ready = (inflight_reads + fifo_count) < RSP_DEPTH. req_ready is registered or derived only from state. It never depends on req_valid or req_we.
- Accepted write: registered pins are CEN=0, GWEN=0, WEN=~req_wmask, A=req_addr, D=req_wdata. A write produces no response.
- Accepted write with req_wmask=0: CEN stays 1. No macro access occurs.
- Accepted read: registered pins are CEN=0, GWEN=1, WEN=8'hFF, A=req_addr. D holds its previous value.
- Idle cycle: CEN=1, GWEN=1, WEN=8'hFF. A and D hold their last values.
- Read pipeline: a 2-stage valid tag follows each read. Q is captured into the FIFO at stage 2.
- FIFO: push and pop in the same cycle are allowed, and the count is unchanged. Overflow is impossible by the credit rule. If it occurs, it is a design error; the bench asserts on it.
- Responses are returned in request order.

## Timing

- All macro pins are driven from flops. There is no combinational path from req_* to any pin.
- Reset values: CEN=1, GWEN=1, WEN=8'hFF, A=0, D=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0. Reset also clears the FIFO, the credit count and the init counter.
- Read latency, measured from acceptance at edge E0:
  - E0: pins take the read values for cycle E0–E1.
  - E1: the macro samples the request. Q becomes valid after E1.
  - E2: the controller captures Q. rsp_valid=1 after E2 when the FIFO was empty. Minimum latency is 2 edges.
- Throughput with RSP_DEPTH=4 and rsp_ready held high: one read per cycle, sustained.
- Writes: with no backpressure, one write per cycle is sustained.
- Sweep: the first edge after RSTN deassertion drives A=0, and the 128th edge drives A=127. The 129th edge sets CEN=1 and init_done=1; req_ready may rise on that same edge.
- Reset mid-operation: all state clears immediately, including in-flight reads, which are discarded. CEN returns to 1 asynchronously. After release, the sweep restarts from address 0.

## Test plan

- Sweep: reset, INIT_EN=1, INIT_VALUE=8'hA5 -> exactly 128 cycles with CEN=0/GWEN=0, addresses 0..127 in order. init_done rises on the 129th edge. A read of address 64 then returns 8'hA5.
- Masked write then read: write addr 7, wdata 8'hFF, wmask 8'h0F over init 8'h00 -> WEN=8'hF0 on the pins. A read of addr 7 returns 8'h0F two edges after acceptance.
- Backpressure: rsp_ready=0, issue 6 back-to-back reads -> only 4 accepted (req_ready falls after the 4th). Releasing rsp_ready returns 4 responses in order, then the remaining 2 are accepted.
- Streaming: rsp_ready=1, 16 consecutive reads of addresses 0..15 -> req_ready stays 1 and rsp_valid is high for 16 consecutive cycles starting 2 edges after the first accept.
- Zero-mask write and simultaneous push/pop: write with wmask=0 -> CEN stays 1. FIFO at 1 entry with pop and push on the same edge -> count stays 1 and data order is preserved.
- Reset mid-read: assert RSTN=0 one cycle after a read is accepted -> CEN=1 and rsp_valid=0 immediately. No response ever appears for that read. The sweep restarts at A=0.

Source files
------------

// File: rtl/sram128x8_ctrl.sv
`timescale 1ns/1ps
// sram128x8_ctrl: valid/ready front end for the gf180 128x8 SRAM macro.
// Power-up sweep, flop-driven macro pins, credit-limited in-order reads.
module sram128x8_ctrl #(
  parameter bit         INIT_EN    = 1'b1,
  parameter logic [7:0] INIT_VALUE = 8'h00,
  parameter int         RSP_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [7:0] req_wmask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       init_done,
  output logic       CEN,
  output logic       GWEN,
  output logic [7:0] WEN,
  output logic [6:0] A,
  output logic [7:0] D,
  input  logic [7:0] Q
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [2:0] LAST = 3'(RSP_DEPTH - 1);
  localparam logic [3:0] CRED = 4'(RSP_DEPTH);

  state_t     state;
  logic [6:0] cnt;
  logic       init_last;

  logic       rd_s1;
  logic       rd_s2;
  logic [7:0] fifo_mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] fifo_cnt;
  logic [3:0] used;

  logic       accept;
  logic       wr_go;
  logic       rd_go;
  logic       push;
  logic       pop;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == LAST) ? 3'd0 : p + 3'd1;
  endfunction

  assign used      = 4'(rd_s1) + 4'(rd_s2) + fifo_cnt;
  assign req_ready = (state == RUN) && (used < CRED);

  assign accept = req_valid && req_ready;
  assign wr_go  = accept && req_we && (req_wmask != 8'h00);
  assign rd_go  = accept && !req_we;

  assign rsp_valid = (fifo_cnt != 4'd0);
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign push      = rd_s2;
  assign pop       = rsp_valid && rsp_ready;

  // Sweep/run sequencer; every macro pin comes straight from a flop here.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= INIT;
      cnt       <= 7'd0;
      init_last <= 1'b0;
      init_done <= 1'b0;
      CEN       <= 1'b1;
      GWEN      <= 1'b1;
      WEN       <= 8'hFF;
      A         <= 7'd0;
      D         <= 8'd0;
    end else begin
      CEN  <= 1'b1;
      GWEN <= 1'b1;
      WEN  <= 8'hFF;
      unique case (state)
        INIT: begin
          if (!INIT_EN || init_last) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            CEN       <= 1'b0;
            GWEN      <= 1'b0;
            WEN       <= 8'h00;
            A         <= cnt;
            D         <= INIT_VALUE;
            cnt       <= cnt + 7'd1;
            init_last <= (cnt == 7'd127);
          end
        end
        RUN: begin
          unique case (1'b1)
            wr_go: begin
              CEN  <= 1'b0;
              GWEN <= 1'b0;
              WEN  <= ~req_wmask;
              A    <= req_addr;
              D    <= req_wdata;
            end
            rd_go: begin
              CEN <= 1'b0;
              A   <= req_addr;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  // Read tag pipeline and response FIFO; Q lands two edges after accept.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_s1    <= 1'b0;
      rd_s2    <= 1'b0;
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      fifo_cnt <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        fifo_mem[i] <= 8'd0;
      end
    end else begin
      rd_s1 <= rd_go;
      rd_s2 <= rd_s1;
      if (push) begin
        fifo_mem[wr_ptr] <= Q;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 4'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram128x8_ctrl.sv
`timescale 1ns/1ps
// tb_sram128x8_ctrl: directed bench with a behavioural SRAM macro and a
// transaction-level reference model compared on every falling edge.
module tb_sram128x8_ctrl;

  localparam int         DEPTH = 4;
  localparam logic [7:0] IV    = 8'hA5;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_wdata = 8'd0;
  logic [7:0] req_wmask = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic       CEN;
  logic       GWEN;
  logic [7:0] WEN;
  logic [6:0] A;
  logic [7:0] D;
  logic [7:0] Q = 8'h00;

  sram128x8_ctrl #(
    .INIT_EN    (1'b1),
    .INIT_VALUE (IV),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .CEN       (CEN),
    .GWEN      (GWEN),
    .WEN       (WEN),
    .A         (A),
    .D         (D),
    .Q         (Q)
  );

  always #5 CLK = ~CLK;

  // Macro: samples pins at the edge, Q updates after a read edge.
  logic [7:0] sram [128];
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       Q <= sram[A];
    end
  end

  typedef struct {
    logic [7:0] data;
    int         rc;
  } rsp_t;

  rsp_t       mq[$];
  logic [7:0] ref_mem [128];
  int         e = 0;
  int         cyc = 0;
  logic       m_cen = 1'b1;
  logic       m_gwen = 1'b1;
  logic [7:0] m_wen = 8'hFF;
  logic [6:0] m_a = 7'd0;
  logic [7:0] m_d = 8'd0;
  logic       m_ready = 1'b0;
  logic       m_done = 1'b0;
  logic       pop_m;
  logic       acc_m;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  logic       snap_v = 1'b0;
  logic [7:0] snap_d = 8'd0;
  int         stalls = 0;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got %0h want %0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got %0d want %0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset decide sweep pins; afterwards each
  // handshake maps to pin values, a memory update or a queued response.
  initial forever begin
    @(posedge CLK or negedge RSTN);
    if (!RSTN) begin
      e = 0;
      mq.delete();
      m_cen = 1'b1; m_gwen = 1'b1; m_wen = 8'hFF;
      m_a = 7'd0; m_d = 8'd0;
      m_ready = 1'b0; m_done = 1'b0;
    end else begin
      pop_m = (mq.size() > 0) && (mq[0].rc <= cyc) && rsp_ready;
      acc_m = req_valid && m_ready;
      cyc++;
      e++;
      if (pop_m) void'(mq.pop_front());
      m_cen = 1'b1; m_gwen = 1'b1; m_wen = 8'hFF;
      if (e <= 128) begin
        m_cen = 1'b0; m_gwen = 1'b0; m_wen = 8'h00;
        m_a = 7'(e - 1); m_d = IV;
      end else if (e == 129) begin
        m_done = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = IV;
      end else if (acc_m && req_we) begin
        if (req_wmask != 8'h00) begin
          m_cen = 1'b0; m_gwen = 1'b0; m_wen = ~req_wmask;
          m_a = req_addr; m_d = req_wdata;
        end
        ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask)
                          | (req_wdata & req_wmask);
      end else if (acc_m) begin
        m_cen = 1'b0; m_a = req_addr;
        mq.push_back('{ref_mem[req_addr], cyc + 2});
        assert (mq.size() <= DEPTH) else $error("response overflow");
      end
      m_ready = (e >= 129) && (mq.size() < DEPTH);
    end
  end

  // Compare DUT against model; also log every popped response.
  initial forever begin
    logic ev;
    @(negedge CLK);
    ev = (mq.size() > 0) && (mq[0].rc <= cyc);
    chk("CEN", 8'(CEN), 8'(m_cen));
    chk("GWEN", 8'(GWEN), 8'(m_gwen));
    chk("WEN", WEN, m_wen);
    chk("A", 8'(A), 8'(m_a));
    chk("D", D, m_d);
    chk("req_ready", 8'(req_ready), 8'(m_ready));
    chk("init_done", 8'(init_done), 8'(m_done));
    chk("rsp_valid", 8'(rsp_valid), 8'(ev));
    if (ev) chk("rsp_rdata", rsp_rdata, mq[0].data);
    if (RSTN && snap_v && rsp_ready) got.push_back(snap_d);
    snap_v = RSTN && rsp_valid;
    snap_d = rsp_rdata;
  end

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic send(input logic we, input logic [6:0] a,
                      input logic [7:0] wd, input logic [7:0] wm);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we = we; req_addr = a; req_wdata = wd; req_wmask = wm;
    while (!req_ready && n < 200) begin
      @(negedge CLK); #1;
      n++;
    end
    stalls += n;
    if (n >= 200) chki("accept_timeout", n, 0);
    @(negedge CLK); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cen_low;
    logic [6:0] a_first;
    logic [6:0] a_last;

    repeat (3) @(negedge CLK);
    #1 RSTN = 1'b1;

    n = 0; cen_low = 0; a_first = 7'h7F; a_last = 7'h00;
    while (!init_done && n < 300) begin
      @(negedge CLK);
      n++;
      if (!CEN) cen_low++;
      if (n == 1) a_first = A;
      if (n == 128) a_last = A;
    end
    chki("sweep_edges", n, 129);
    chki("sweep_writes", cen_low, 128);
    chk("sweep_a_first", 8'(a_first), 8'h00);
    chk("sweep_a_last", 8'(a_last), 8'h7F);
    #1;

    rsp_ready = 1'b1;
    got.delete();
    send(1'b0, 7'd64, 8'h00, 8'h00);
    repeat (4) @(negedge CLK);
    #1;
    chki("init_read_n", got.size(), 1);
    chk("init_read_val", got[0], 8'hA5);

    send(1'b1, 7'd7, 8'h00, 8'hFF);
    send(1'b1, 7'd7, 8'hFF, 8'h0F);
    chk("masked_wen", WEN, 8'hF0);
    send(1'b0, 7'd7, 8'h00, 8'h00);
    @(negedge CLK);
    chk("lat_e1_valid", 8'(rsp_valid), 8'h00);
    @(negedge CLK);
    chk("lat_e2_valid", 8'(rsp_valid), 8'h01);
    chk("lat_e2_data", rsp_rdata, 8'h0F);
    #1;

    send(1'b1, 7'd7, 8'h00, 8'h00);
    chk("zero_mask_cen", 8'(CEN), 8'h01);
    got.delete();
    send(1'b0, 7'd7, 8'h00, 8'h00);
    repeat (4) @(negedge CLK);
    #1;
    chk("zero_mask_keep", got[0], 8'h0F);

    for (int i = 0; i < 6; i++)
      send(1'b1, 7'(20 + i), 8'(8'h30 + i), 8'hFF);
    rsp_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) send(1'b0, 7'(20 + i), 8'h00, 8'h00);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd24;
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (!req_ready) n++;
    end
    chki("bp_stall", n, 6);
    chk("bp_full_valid", 8'(rsp_valid), 8'h01);
    #1 rsp_ready = 1'b1;
    send(1'b0, 7'd24, 8'h00, 8'h00);
    send(1'b0, 7'd25, 8'h00, 8'h00);
    repeat (6) @(negedge CLK);
    #1;
    chki("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_order", got[i], 8'(8'h30 + i));

    got.delete();
    stalls = 0;
    for (int i = 0; i < 16; i++) send(1'b0, 7'(i), 8'h00, 8'h00);
    repeat (5) @(negedge CLK);
    #1;
    chki("stream_stalls", stalls, 0);
    chki("stream_count", got.size(), 16);
    chk("stream_d0", got[0], 8'hA5);
    chk("stream_d7", got[7], 8'h0F);

    got.delete();
    rsp_ready = 1'b0;
    send(1'b0, 7'd20, 8'h00, 8'h00);
    send(1'b0, 7'd21, 8'h00, 8'h00);
    @(negedge CLK);
    chk("pp_head", rsp_rdata, 8'h30);
    #1 rsp_ready = 1'b1;
    @(negedge CLK);
    chk("pp_valid", 8'(rsp_valid), 8'h01);
    chk("pp_next", rsp_rdata, 8'h31);
    #1 rsp_ready = 1'b0;
    @(negedge CLK);
    chk("pp_hold", rsp_rdata, 8'h31);
    #1 rsp_ready = 1'b1;
    @(negedge CLK);
    chk("pp_drained", 8'(rsp_valid), 8'h00);
    #1;
    chki("pp_count", got.size(), 2);
    chk("pp_order1", got[1], 8'h31);

    send(1'b0, 7'd64, 8'h00, 8'h00);
    RSTN = 1'b0;
    #1;
    chk("rst_cen", 8'(CEN), 8'h01);
    chk("rst_valid", 8'(rsp_valid), 8'h00);
    got.delete();
    repeat (2) @(negedge CLK);
    #1 RSTN = 1'b1;
    @(negedge CLK);
    chk("rst_sweep_a", 8'(A), 8'h00);
    chk("rst_sweep_cen", 8'(CEN), 8'h00);
    n = 0;
    while (!init_done && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chki("rst_sweep_edges", n, 128);
    repeat (4) @(negedge CLK);
    chki("rst_no_rsp", got.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
